multicycle_control_unit: RTL

FSM control unit for the SigmaCore multicycle CPU. Sequences every instruction through fetch, decode, execute, memory and write-back states and drives all datapath control inputs: PC/IR/register/ALUOut enables, mux selects, immediate type and ALU operation class. Sits directly upstream of the multicycle datapath:
- consumes the latched instruction register and the ALU zero flag;
- produces one control word per cycle.

---
 rtl/sigma_pkg.sv | 52 +++++
 rtl/multicycle_control_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sigma_pkg.sv
// rtl/sigma_pkg.sv - SigmaCore shared types and encodings for the multicycle control unit
package sigma_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        ALU_WB    = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WB    = 4'd7,
        MEM_WRITE = 4'd8,
        BRANCH    = 4'd9,
        BR_NT     = 4'd10,
        JALR_ADDR = 4'd11,
        JUMP      = 4'd12,
        JUMP_WB   = 4'd13,
        TRAP      = 4'd14
    } cu_state_t;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic MEM_TO_REG_ALU_RES = 1'b0;
    localparam logic MEM_TO_REG_MEM     = 1'b1;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    localparam logic [1:0] ALU_B_REG  = 2'b00;
    localparam logic [1:0] ALU_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_B_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - SigmaCore multicycle FSM control unit
module multicycle_control_unit
    import sigma_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instruction_in,
    input  logic        alu_zero_in,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic        mem_read,
    output logic [1:0]  pc_source,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [1:0]  alu_op_type,
    output logic        reg_a_write,
    output logic        reg_b_write,
    output logic        alu_out_write,
    output logic [3:0]  state_out,
    output logic        instr_done_out,
    output logic        trap_out
);

    cu_state_t state_q, state_d;
    logic      jalr_q, jalr_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_taken;
    logic       unused_instr_bits;

    assign opcode            = instruction_in[6:0];
    assign funct3            = instruction_in[14:12];
    assign br_taken          = alu_zero_in ^ funct3[0];
    assign unused_instr_bits = ^{instruction_in[31:15], instruction_in[11:7]};

    logic       pcw_c, irw_c, rw_c, mw_c, mr_c, m2r_c, asa_c;
    logic       raw_c, rbw_c, aow_c, done_c, trap_c;
    logic [1:0] ps_c, asb_c, aop_c;
    logic [2:0] imm_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            jalr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            jalr_q  <= jalr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        jalr_d  = 1'b0;
        pcw_c   = 1'b0;
        irw_c   = 1'b0;
        rw_c    = 1'b0;
        mw_c    = 1'b0;
        mr_c    = 1'b0;
        m2r_c   = MEM_TO_REG_ALU_RES;
        asa_c   = 1'b0;
        raw_c   = 1'b0;
        rbw_c   = 1'b0;
        aow_c   = 1'b0;
        done_c  = 1'b0;
        trap_c  = 1'b0;
        ps_c    = PC_SRC_ALU;
        asb_c   = ALU_B_REG;
        aop_c   = ALUOP_ADD;
        imm_c   = IMM_I;

        unique case (state_q)
            FETCH: begin
                irw_c   = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                // ALUOut <= PC + imm so branch/JAL targets are ready next cycle
                raw_c = 1'b1;
                rbw_c = 1'b1;
                aow_c = 1'b1;
                asa_c = 1'b1;
                asb_c = ALU_B_IMM;
                imm_c = (opcode == OPC_JAL) ? IMM_J : IMM_B;
                unique case (opcode)
                    OPC_RTYPE:           state_d = EXEC_R;
                    OPC_ITYPE:           state_d = EXEC_I;
                    OPC_LOAD, OPC_STORE: state_d = MEM_ADDR;
                    OPC_BRANCH:          state_d = BRANCH;
                    OPC_JAL:             state_d = JUMP;
                    OPC_JALR:            state_d = JALR_ADDR;
                    default:             state_d = TRAP;
                endcase
            end
            EXEC_R: begin
                aop_c   = ALUOP_RTYPE;
                aow_c   = 1'b1;
                state_d = ALU_WB;
            end
            EXEC_I: begin
                asb_c   = ALU_B_IMM;
                imm_c   = IMM_I;
                aop_c   = ALUOP_ITYPE;
                aow_c   = 1'b1;
                state_d = ALU_WB;
            end
            ALU_WB: begin
                rw_c    = 1'b1;
                asa_c   = 1'b1;
                asb_c   = ALU_B_FOUR;
                pcw_c   = 1'b1;
                done_c  = 1'b1;
                state_d = FETCH;
            end
            MEM_ADDR: begin
                asb_c   = ALU_B_IMM;
                aow_c   = 1'b1;
                imm_c   = (opcode == OPC_STORE) ? IMM_S : IMM_I;
                state_d = (opcode == OPC_STORE) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mr_c    = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                rw_c    = 1'b1;
                m2r_c   = MEM_TO_REG_MEM;
                asa_c   = 1'b1;
                asb_c   = ALU_B_FOUR;
                pcw_c   = 1'b1;
                done_c  = 1'b1;
                state_d = FETCH;
            end
            MEM_WRITE: begin
                mw_c    = 1'b1;
                asa_c   = 1'b1;
                asb_c   = ALU_B_FOUR;
                pcw_c   = 1'b1;
                done_c  = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                aop_c = ALUOP_BRANCH;
                if (funct3[2:1] != 2'b00) begin
                    state_d = TRAP;
                end else if (br_taken) begin
                    pcw_c   = 1'b1;
                    ps_c    = PC_SRC_ALUOUT;
                    done_c  = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = BR_NT;
                end
            end
            BR_NT: begin
                asa_c   = 1'b1;
                asb_c   = ALU_B_FOUR;
                pcw_c   = 1'b1;
                done_c  = 1'b1;
                state_d = FETCH;
            end
            JALR_ADDR: begin
                asb_c   = ALU_B_IMM;
                imm_c   = IMM_I;
                aow_c   = 1'b1;
                jalr_d  = 1'b1;
                state_d = JUMP;
            end
            JUMP: begin
                // PC loads the old ALUOut target while ALUOut captures PC+4 for the link
                asa_c   = 1'b1;
                asb_c   = ALU_B_FOUR;
                aow_c   = 1'b1;
                pcw_c   = 1'b1;
                ps_c    = jalr_q ? PC_SRC_JALR : PC_SRC_ALUOUT;
                state_d = JUMP_WB;
            end
            JUMP_WB: begin
                rw_c    = 1'b1;
                done_c  = 1'b1;
                state_d = FETCH;
            end
            TRAP: begin
                trap_c  = 1'b1;
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
            end
        endcase
    end

    // Holding reset forces every output, state_out included, to zero
    assign pc_write       = reset_n & pcw_c;
    assign ir_write       = reset_n & irw_c;
    assign reg_write      = reset_n & rw_c;
    assign mem_write      = reset_n & mw_c;
    assign mem_read       = reset_n & mr_c;
    assign pc_source      = reset_n ? ps_c : 2'b00;
    assign mem_to_reg     = reset_n & m2r_c;
    assign alu_src_a      = reset_n & asa_c;
    assign alu_src_b      = reset_n ? asb_c : 2'b00;
    assign imm_src        = reset_n ? imm_c : 3'b000;
    assign alu_op_type    = reset_n ? aop_c : 2'b00;
    assign reg_a_write    = reset_n & raw_c;
    assign reg_b_write    = reset_n & rbw_c;
    assign alu_out_write  = reset_n & aow_c;
    assign state_out      = reset_n ? state_q : 4'd0;
    assign instr_done_out = reset_n & done_c;
    assign trap_out       = reset_n & trap_c;

endmodule
